// File: rtl/rvc_asap_eot_monitor.sv
// rvc_asap_eot_monitor
// This is an end-of-test monitor for multi-hart rvc_asap cores.
//   - It watches the 101H instruction of every hart for EBREAK.
//   - When the end condition is met, it waits a few cycles so that pending stores
//     can retire.
//   - It then streams the D_MEM snapshot window out as one 32-bit word per beat,
//     using ready/valid handshaking.
// Optional feature: define RVC_EOT_TIMEOUT_EN to add a cycle watchdog that ends the
// test after TIMEOUT_CYCLES cycles in RUN.
//
// state | meaning
// RUN   | counting cycles, collecting per-hart EBREAKs
// DRAIN | waiting DRAIN_CYCLES for store retirement
// DUMP  | reading D_MEM and streaming beats out
// DONE  | snapshot complete, hold until reset
module rvc_asap_eot_monitor #(
  parameter int          NUM_HARTS      = 1,
  parameter int          END_MODE       = 0,
  parameter int          DRAIN_CYCLES   = 4,
  parameter logic [31:0] DMEM_OFFSET    = 32'h0000_1000,
  parameter int          DMEM_BYTES     = 4096,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                      Clock,
  input  logic                      Rst,
  input  logic [32*NUM_HARTS-1:0]   InstQ101H,
  input  logic [NUM_HARTS-1:0]      InstVldQ101H,
  output logic                      SnapRdEn,
  output logic [31:0]               SnapRdAddr,
  input  logic [31:0]               SnapRdData,
  output logic                      SnapVld,
  input  logic                      SnapReady,
  output logic [31:0]               SnapAddr,
  output logic [31:0]               SnapData,
  output logic [NUM_HARTS-1:0]      HartHalted,
  output logic [31:0]               CycleCount,
  output logic [1:0]                EotStatus,
  output logic                      EotDone
);

  localparam logic [31:0] EBREAK     = 32'h0010_0073;
  localparam logic [31:0] NUM_WORDS  = 32'(DMEM_BYTES / 4);
  localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

  // A bad window or timeout setting would give a silently wrong dump, so refuse to elaborate.
  if ((DMEM_BYTES < 4) || ((DMEM_BYTES % 4) != 0) || (DMEM_OFFSET[1:0] != 2'b00) ||
      (TIMEOUT_CYCLES < 1) || (NUM_HARTS < 1)) begin : g_param_check
    $error("rvc_asap_eot_monitor: illegal parameter combination");
  end

  typedef enum logic [1:0] {RUN, DRAIN, DUMP, DONE} state_t;

  state_t                 state_q, state_nxt;
  logic [NUM_HARTS-1:0]   halted_q, halted_nxt, ebreak_hit;
  logic [31:0]            cycle_q;
  logic [1:0]             status_q;
  logic [31:0]            drain_q;
  logic                   end_cond, timeout_hit, run_end;

  logic [31:0]            rd_ptr_q, words_left_q, rd_addr_q;
  logic                   inflight_q;
  logic [31:0]            fifo_addr_q [2];
  logic [31:0]            fifo_data_q [2];
  logic                   wr_idx_q, rd_idx_q;
  logic [1:0]             count_q;
  logic                   done_q;
  logic                   in_dump, snap_vld, pop, issue, last_pop;

  // Detect EBREAK on each hart and form the end condition from the halted set after this cycle.
  always_comb begin
    ebreak_hit = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      ebreak_hit[h] = InstVldQ101H[h] && (InstQ101H[32*h +: 32] == EBREAK);
    end
    halted_nxt = halted_q | ebreak_hit;
    end_cond   = (END_MODE == 0) ? (&halted_nxt) : (|halted_nxt);
  end

`ifdef RVC_EOT_TIMEOUT_EN
  assign timeout_hit = (state_q == RUN) && (cycle_q == 32'(TIMEOUT_CYCLES - 1)) && !end_cond;
`else
  assign timeout_hit = 1'b0;
`endif

  assign run_end  = (state_q == RUN) && (end_cond || timeout_hit);

  // Dump flow control: at most two buffered beats plus one read in flight.
  assign in_dump  = (state_q == DUMP);
  assign snap_vld = in_dump && (count_q != 2'd0);
  assign pop      = snap_vld && SnapReady;
  assign issue    = in_dump && (words_left_q != 32'd0) &&
                    (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign last_pop = in_dump && (words_left_q == 32'd0) && !inflight_q &&
                    (count_q == 2'd1) && pop;

  // State register.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) state_q <= RUN;
    else      state_q <= state_nxt;
  end

  // Next-state logic. A zero drain length skips DRAIN entirely.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      RUN:     if (run_end) state_nxt = (DRAIN_CYCLES == 0) ? DUMP : DRAIN;
      DRAIN:   if (drain_q == 32'd0) state_nxt = DUMP;
      DUMP:    if (last_pop) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  // Run-phase bookkeeping. All of it freezes once RUN is left.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      cycle_q  <= 32'd0;
      halted_q <= '0;
      status_q <= 2'b00;
    end else if (state_q == RUN) begin
      if (cycle_q != 32'hFFFF_FFFF) cycle_q <= cycle_q + 32'd1;
      halted_q <= halted_nxt;
      if (end_cond)         status_q <= 2'b01;
      else if (timeout_hit) status_q <= 2'b10;
    end
  end

  // Drain down-counter, loaded on leaving RUN and terminal at zero.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst)                             drain_q <= 32'd0;
    else if (run_end)                     drain_q <= DRAIN_LOAD;
    else if (state_q == DRAIN && drain_q != 32'd0) drain_q <= drain_q - 32'd1;
  end

  // Read issue, in-flight tracking and the two-entry beat buffer.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      rd_ptr_q     <= DMEM_OFFSET;
      words_left_q <= NUM_WORDS;
      rd_addr_q    <= 32'd0;
      inflight_q   <= 1'b0;
      wr_idx_q     <= 1'b0;
      rd_idx_q     <= 1'b0;
      count_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_addr_q[i] <= 32'd0;
        fifo_data_q[i] <= 32'd0;
      end
    end else begin
      inflight_q <= issue;
      if (issue) begin
        rd_addr_q    <= rd_ptr_q;
        rd_ptr_q     <= rd_ptr_q + 32'd4;
        words_left_q <= words_left_q - 32'd1;
      end
      if (inflight_q) begin
        fifo_addr_q[wr_idx_q] <= rd_addr_q;
        fifo_data_q[wr_idx_q] <= SnapRdData;
        wr_idx_q              <= ~wr_idx_q;
      end
      if (pop) rd_idx_q <= ~rd_idx_q;
      case ({inflight_q, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Completion flag, raised the cycle after the final beat is accepted.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst)          done_q <= 1'b0;
    else if (last_pop) done_q <= 1'b1;
  end

  assign SnapRdEn   = issue;
  assign SnapRdAddr = issue ? rd_ptr_q : 32'd0;
  assign SnapVld    = snap_vld;
  assign SnapAddr   = snap_vld ? fifo_addr_q[rd_idx_q] : 32'd0;
  assign SnapData   = snap_vld ? fifo_data_q[rd_idx_q] : 32'd0;
  assign HartHalted = halted_q;
  assign CycleCount = cycle_q;
  assign EotStatus  = status_q;
  assign EotDone    = done_q;

endmodule
